i2c_master_controller: RTL and testbench
========================================

# i2c_master_controller

Single-byte I2C master that turns a one-cycle command on the system clock into a complete bus transaction on SCL/SDA. The sequence is START, 7-bit address plus R/W, address ACK check, one data byte written or read, ACK/NACK, then STOP. It sits directly upstream of the I2C slave controller: it drives the `scl`/`sda` wires the slave samples, and it returns the slave's read byte and ACK status to the host logic.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per SCL quarter-period. One SCL bit takes 4·CLK_DIV cycles. Legal range is ≥ 1.
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: one-cycle command strobe. It is accepted only when `busy` = 0.
- `addr`, input, 7: target address. Captured when `start` is accepted.
- `rw`, input, 1: direction. 0 = write, 1 = read. Captured when `start` is accepted.
- `wr_data`, input, 8: byte to write. Captured when `start` is accepted.
- `rd_data`, output, 8: byte read from the slave. Updated only at the end of a successful read.
- `busy`, output, 1: high from the cycle after acceptance until `done`.
- `done`, output, 1: one-cycle pulse when the STOP condition completes.
- `ack_error`, output, 1: valid with `done`. 1 = address or write-data NACK. Holds its value until the next accepted `start`.
- `scl`, output, 1: bus clock, push-pull. The block does not support clock stretching.
- `sda`, inout, 1: open-drain. The block drives only 0 or Z. It reads `sda` for ACK and read-data bits.

## Operation
- Bit engine:
  - Every bit has four phases, P0 to P3, each CLK_DIV cycles long.
  - SCL is low in P0 and P1, and high in P2 and P3.
  - SDA changes only at P0 entry.
  - `sda` is sampled on the last cycle of P2.
- State machine states: IDLE, START, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, STOP.
- IDLE: `scl` = 1, `sda` released. On accepted `start`: capture `addr`, `rw`, `wr_data`, clear `ack_error`, go to START.
- START (one bit time):
  - P0–P1: SCL high, SDA released.
  - P2–P3: SCL high, SDA driven 0. This is the START condition.
  - Then go to ADDR.
- ADDR: shift out {addr, rw}, MSB first, 8 bits. Releasing SDA means a 1 bit. Then go to ADDR_ACK.
- ADDR_ACK: release SDA and sample it.
  - Sample 1 (NACK): set `ack_error`, go to STOP.
  - Sample 0 and `rw` = 0: go to WR_DATA.
  - Sample 0 and `rw` = 1: go to RD_DATA.
- WR_DATA: shift out `wr_data`, MSB first. Then go to WR_ACK, which samples the slave ACK. NACK sets `ack_error`. Either way, go to STOP.
- RD_DATA: release SDA and sample 8 bits MSB first into a shift register. Then go to RD_ACK.
- RD_ACK: master leaves SDA released, which sends NACK to end the read. Load `rd_data` from the shift register, go to STOP.
- STOP (one bit time):
  - P0–P1: SCL low, SDA driven 0.
  - P2: SCL high, SDA still 0.
  - P3: SCL high, SDA released. This is the STOP condition.
  - Then pulse `done`, drop `busy`, return to IDLE.
- Bit counter: 3 bits, counts down 7→0, reloaded to 7 on entry to each byte state.
- Phase counter: counts 0..CLK_DIV−1. It wraps to 0 on phase advance; the phase index wraps P3→P0.

## Timing
- Reset values: `scl` = 1, `sda` = Z, `busy` = 0, `done` = 0, `ack_error` = 0, `rd_data` = 8'h00. State is IDLE and all counters are 0.
- `busy` rises on the cycle after `start` is sampled. The first SCL phase begins in that same cycle.
- Full transaction length: 20 bit times = 80·CLK_DIV cycles from acceptance to `done`. That is START 1 + address 9 + data 9 + STOP 1 bit times.
- Address-NACK transaction length: 11 bit times = 44·CLK_DIV cycles.
- `done` and `busy` falling occur in the same cycle.
- `start` while `busy` = 1 is ignored, with no queuing.
- `start` in the same cycle as `done`: ignored. `busy` is still 1 in that cycle.
- `rst_n` low mid-transaction: immediate return to IDLE with reset outputs. SCL goes high and SDA is released. No STOP is generated and no `done` is pulsed.
- `rd_data` is unchanged on a write and on an address NACK.

## Structure
- Package `i2c_pkg`, shared with the slave controller. It holds:
  - the state enum;
  - phase constants P0..P3;
  - `I2C_ADDR_W` = 7;
  - `I2C_DATA_W` = 8;
  - the test slave address 7'h2A.
- Sub-module `i2c_phase_gen`. It holds the CLK_DIV phase counter and the 2-bit phase index, clears on `rst_n` or on an idle signal, and outputs `phase` and a one-cycle `phase_end` strobe. The FSM advances only on `phase_end`.

## Test plan
- Write to the slave model at 7'h2A with `wr_data` = 8'hA5, CLK_DIV = 4:
  - slave `data` = 8'hA5 and slave `addr` = 8'h54;
  - `done` at cycle 320 after acceptance, with `ack_error` = 0.
- Read from 7'h2A, where the slave returns 8'h6B:
  - `rd_data` = 8'h6B and `ack_error` = 0;
  - master SDA released during RD_ACK (NACK), then STOP observed.
- Address 7'h15 with no responder (pull-up only) → `ack_error` = 1, `done` at 44·CLK_DIV cycles, `rd_data` unchanged.
- Second `start` pulsed 10 cycles into a transaction → ignored. Exactly one `done` pulse; captured `addr`/`wr_data` unchanged.
- `rst_n` asserted during the ADDR bit 3:
  - `scl` = 1 and `sda` = Z within the reset cycle;
  - `busy` = 0 and no `done`;
  - a new write after release completes normally.
- Bus monitor on all scenarios: SDA never changes while SCL is high, except at START and STOP.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the master and slave controllers: FSM states,
// bit-phase indices and bus field widths.
package i2c_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ADDR_ACK,
        S_WR_DATA,
        S_WR_ACK,
        S_RD_DATA,
        S_RD_ACK,
        S_STOP
    } i2c_state_e;

    localparam logic [1:0] P0 = 2'd0;
    localparam logic [1:0] P1 = 2'd1;
    localparam logic [1:0] P2 = 2'd2;
    localparam logic [1:0] P3 = 2'd3;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;

    localparam logic [I2C_ADDR_W-1:0] I2C_TEST_ADDR = 7'h2A;

endpackage

// File: rtl/i2c_master_controller_if.sv
// Host-side command/status bundle of the I2C master controller.
interface i2c_master_controller_if;
    import i2c_pkg::*;

    logic                  start;
    logic [I2C_ADDR_W-1:0] addr;
    logic                  rw;
    logic [I2C_DATA_W-1:0] wr_data;
    logic [I2C_DATA_W-1:0] rd_data;
    logic                  busy;
    logic                  done;
    logic                  ack_error;

    modport master (input start, addr, rw, wr_data, output rd_data, busy, done, ack_error);
    modport slave  (output start, addr, rw, wr_data, input rd_data, busy, done, ack_error);

endinterface

// File: rtl/i2c_phase_gen.sv
// Quarter-bit timebase: CLK_DIV-cycle phase counter and 2-bit phase index,
// held at P0 while the controller is idle.
module i2c_phase_gen
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       idle,
    output logic [1:0] phase,
    output logic       phase_end
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign phase_end = !idle && (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= P0;
        end else if (idle) begin
            cnt   <= '0;
            phase <= P0;
        end else if (phase_end) begin
            cnt   <= '0;
            phase <= phase + 2'd1;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_master_controller.sv
// Single-byte I2C master: START, address+R/W, ACK, one data byte, ACK/NACK, STOP.
//
// state      | meaning
// S_IDLE     | bus released, waiting for start
// S_START    | SDA falls while SCL high
// S_ADDR     | shifting {addr, rw} out MSB first
// S_ADDR_ACK | sampling slave address ACK
// S_WR_DATA  | shifting wr_data out MSB first
// S_WR_ACK   | sampling slave data ACK
// S_RD_DATA  | sampling 8 read bits
// S_RD_ACK   | master NACK, load rd_data
// S_STOP     | SDA rises while SCL high
module i2c_master_controller
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    i2c_master_controller_if.master  host,
    output logic                     scl,
    inout  wire                      sda
);

    i2c_state_e            state, state_d;
    logic [1:0]            phase;
    logic                  phase_end;
    logic                  bit_end;
    logic                  sample;
    logic                  accept;
    logic [2:0]            bit_cnt;
    logic [I2C_ADDR_W-1:0] addr_q;
    logic                  rw_q;
    logic [I2C_DATA_W-1:0] wr_q;
    logic [I2C_DATA_W-1:0] rd_shift;
    logic [I2C_DATA_W-1:0] rd_q;
    logic                  ack_err_q;
    logic                  sda_smp;
    logic                  sda_low;
    logic                  sda_in;
    logic [7:0]            addr_byte;

    i2c_phase_gen #(.CLK_DIV(CLK_DIV)) u_phase_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .idle      (state == S_IDLE),
        .phase     (phase),
        .phase_end (phase_end)
    );

    assign bit_end   = phase_end && (phase == P3);
    assign sample    = phase_end && (phase == P2);
    assign accept    = (state == S_IDLE) && host.start;
    assign addr_byte = {addr_q, rw_q};
    assign sda_in    = sda;
    assign sda       = sda_low ? 1'b0 : 1'bz;

    assign host.busy      = (state != S_IDLE);
    assign host.done      = bit_end && (state == S_STOP);
    assign host.ack_error = ack_err_q;
    assign host.rd_data   = rd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:     if (host.start) state_d = S_START;
            S_START:    if (bit_end) state_d = S_ADDR;
            S_ADDR:     if (bit_end && bit_cnt == 3'd0) state_d = S_ADDR_ACK;
            S_ADDR_ACK: if (bit_end) state_d = sda_smp ? S_STOP : (rw_q ? S_RD_DATA : S_WR_DATA);
            S_WR_DATA:  if (bit_end && bit_cnt == 3'd0) state_d = S_WR_ACK;
            S_WR_ACK:   if (bit_end) state_d = S_STOP;
            S_RD_DATA:  if (bit_end && bit_cnt == 3'd0) state_d = S_RD_ACK;
            S_RD_ACK:   if (bit_end) state_d = S_STOP;
            S_STOP:     if (bit_end) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Bus drive is decoded from registered state/phase so SDA only moves at P0 entry.
    always_comb begin
        scl     = 1'b1;
        sda_low = 1'b0;
        case (state)
            S_IDLE:    ;
            S_START:   sda_low = (phase >= P2);
            S_ADDR: begin
                scl     = (phase >= P2);
                sda_low = !addr_byte[bit_cnt];
            end
            S_WR_DATA: begin
                scl     = (phase >= P2);
                sda_low = !wr_q[bit_cnt];
            end
            S_STOP: begin
                scl     = (phase >= P2);
                sda_low = (phase != P3);
            end
            default:   scl = (phase >= P2);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            addr_q    <= '0;
            rw_q      <= 1'b0;
            wr_q      <= '0;
            rd_shift  <= '0;
            rd_q      <= '0;
            ack_err_q <= 1'b0;
            sda_smp   <= 1'b1;
        end else begin
            if (accept) begin
                addr_q    <= host.addr;
                rw_q      <= host.rw;
                wr_q      <= host.wr_data;
                ack_err_q <= 1'b0;
            end
            if (bit_end) begin
                if (state_d == state)
                    bit_cnt <= bit_cnt - 3'd1;
                else if (state_d inside {S_ADDR, S_WR_DATA, S_RD_DATA})
                    bit_cnt <= 3'd7;
                else
                    bit_cnt <= '0;
            end
            if (sample) begin
                sda_smp <= sda_in;
                if (state == S_RD_DATA)
                    rd_shift <= {rd_shift[I2C_DATA_W-2:0], sda_in};
            end
            if (bit_end && sda_smp && (state == S_ADDR_ACK || state == S_WR_ACK))
                ack_err_q <= 1'b1;
            if (bit_end && state == S_RD_ACK)
                rd_q <= rd_shift;
        end
    end

endmodule

// File: tb/tb_i2c_master_controller.sv
// Self-checking bench: behavioural I2C slave plus bus monitor, with a
// transaction-level model predicting length, ACK status and read data.
module tb_i2c_master_controller;
    import i2c_pkg::*;

    localparam int D = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scl;
    wire  sda;
    logic slv_low = 1'b0;

    pullup (sda);
    assign sda = slv_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_master_controller_if hif ();

    i2c_master_controller #(.CLK_DIV(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .host  (hif),
        .scl   (scl),
        .sda   (sda)
    );

    int n_total = 0;
    int n_pass  = 0;

    // slave model / bus monitor state
    logic       scl_q = 1'b1;
    logic       sda_q = 1'b1;
    bit         s_act = 0;
    int         sbit = 0;
    bit         s_present = 1;
    bit         s_nack_data = 0;
    logic [7:0] s_rd_byte = 8'h00;
    logic [7:0] s_addr_byte = 8'h00;
    logic [7:0] s_data = 8'h00;
    logic       rdack_sda = 1'b0;
    int         n_start = 0;
    int         n_stop = 0;

    logic [7:0] model_rd = 8'h00;

    always @(negedge clk) begin
        if (!rst_n) begin
            s_act   = 0;
            slv_low = 1'b0;
        end else if (scl_q === 1'b1 && scl === 1'b1 && sda_q !== sda) begin
            slv_low = 1'b0;
            if (sda === 1'b0) begin
                n_start++;
                s_act = 1;
                sbit  = 0;
            end else begin
                n_stop++;
                s_act = 0;
            end
        end else if (s_act && scl_q === 1'b0 && scl === 1'b1) begin
            sbit++;
            if (sbit <= 8)
                s_addr_byte = {s_addr_byte[6:0], sda};
            else if (sbit >= 10 && sbit <= 17)
                s_data = {s_data[6:0], sda};
            else if (sbit == 18)
                rdack_sda = sda;
        end else if (s_act && scl_q === 1'b1 && scl === 1'b0) begin
            slv_low = 1'b0;
            if (s_present && s_addr_byte[7:1] == I2C_TEST_ADDR) begin
                if (sbit == 8)
                    slv_low = 1'b1;
                else if (sbit >= 9 && sbit <= 16 && s_addr_byte[0])
                    slv_low = !s_rd_byte[16 - sbit];
                else if (sbit == 17 && !s_addr_byte[0])
                    slv_low = !s_nack_data;
            end
        end
        scl_q = scl;
        sda_q = sda;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One full command; dup_at > 0 pulses a competing start in that cycle.
    task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] wd,
                           input bit present, input bit nack_data, input logic [7:0] rb,
                           input int dup_at);
        bit   addr_ack;
        bit   exp_err;
        int   exp_len;
        int   k;
        int   done_at;
        int   n_done;
        logic busy_at_done;
        logic err_at_done;
        logic busy_after;

        addr_ack = present && (a == I2C_TEST_ADDR);
        exp_err  = !addr_ack || (!r && nack_data);
        exp_len  = addr_ack ? 80 * D : 44 * D;
        if (r && addr_ack) model_rd = rb;

        s_present   = present;
        s_nack_data = nack_data;
        s_rd_byte   = rb;
        n_start     = 0;
        n_stop      = 0;
        rdack_sda   = 1'b0;
        done_at      = 0;
        n_done       = 0;
        busy_at_done = 1'b0;
        err_at_done  = 1'b0;
        busy_after   = 1'b1;

        @(negedge clk);
        hif.start   = 1'b1;
        hif.addr    = a;
        hif.rw      = r;
        hif.wr_data = wd;
        @(negedge clk);
        hif.start   = 1'b0;
        hif.addr    = ~a;
        hif.rw      = ~r;
        hif.wr_data = ~wd;
        k = 1;
        check("busy_rise", hif.busy, 1'b1);
        while (k <= 100 * D) begin
            if (dup_at > 0 && k == dup_at) begin
                hif.start   = 1'b1;
                hif.addr    = a ^ 7'h55;
                hif.wr_data = wd ^ 8'hFF;
            end
            if (dup_at > 0 && k == dup_at + 1) hif.start = 1'b0;
            if (hif.done === 1'b1) begin
                n_done++;
                if (done_at == 0) begin
                    done_at      = k;
                    busy_at_done = hif.busy;
                    err_at_done  = hif.ack_error;
                end
            end
            if (done_at != 0 && k == done_at + 1) busy_after = hif.busy;
            if (done_at != 0 && k == done_at + 4) break;
            @(negedge clk);
            k++;
        end
        hif.start = 1'b0;

        check("done_cycle", done_at, exp_len);
        check("done_count", n_done, 1);
        check("busy_at_done", busy_at_done, 1'b1);
        check("busy_fall", busy_after, 1'b0);
        check("ack_error", err_at_done, exp_err);
        check("ack_error_hold", hif.ack_error, exp_err);
        check("rd_data", hif.rd_data, model_rd);
        check("bus_start_events", n_start, 1);
        check("bus_stop_events", n_stop, 1);
        check("scl_idle", scl, 1'b1);
        if (addr_ack) check("slave_addr", s_addr_byte, {a, r});
        if (addr_ack && !r) check("slave_data", s_data, wd);
        if (addr_ack && r) check("rd_ack_released", rdack_sda, 1'b1);
    endtask

    initial begin
        hif.start   = 1'b0;
        hif.addr    = '0;
        hif.rw      = 1'b0;
        hif.wr_data = '0;
        repeat (3) @(negedge clk);
        check("rst_scl", scl, 1'b1);
        check("rst_sda", sda, 1'b1);
        check("rst_busy", hif.busy, 1'b0);
        check("rst_done", hif.done, 1'b0);
        check("rst_ack_error", hif.ack_error, 1'b0);
        check("rst_rd_data", hif.rd_data, 8'h00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_txn(7'h2A, 1'b0, 8'hA5, 1, 0, 8'h00, 0);
        run_txn(7'h2A, 1'b1, 8'h00, 1, 0, 8'h6B, 0);
        run_txn(7'h15, 1'b0, 8'h3C, 1, 0, 8'h00, 0);
        run_txn(7'h2A, 1'b1, 8'h00, 0, 0, 8'h11, 0);
        run_txn(7'h2A, 1'b0, 8'h5A, 1, 0, 8'h00, 10);
        run_txn(7'h2A, 1'b0, 8'hC3, 1, 1, 8'h00, 0);
        run_txn(7'h2A, 1'b0, 8'h81, 1, 0, 8'h00, 80 * D);

        // reset during ADDR bit 3 (fifth address bit), while SCL is low
        @(negedge clk);
        hif.start   = 1'b1;
        hif.addr    = 7'h2A;
        hif.rw      = 1'b0;
        hif.wr_data = 8'hF0;
        @(negedge clk);
        hif.start = 1'b0;
        repeat (5 * 4 * D) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_scl", scl, 1'b1);
        check("mid_rst_sda", sda, 1'b1);
        check("mid_rst_busy", hif.busy, 1'b0);
        check("mid_rst_done", hif.done, 1'b0);
        model_rd = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_rst_no_done", hif.done, 1'b0);
        end
        check("mid_rst_rd_data", hif.rd_data, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", hif.busy, 1'b0);
        run_txn(7'h2A, 1'b0, 8'h3C, 1, 0, 8'h00, 0);

        for (int i = 0; i < 8; i++) begin
            logic [6:0] ra;
            ra = ($urandom_range(0, 2) != 0) ? I2C_TEST_ADDR : 7'($urandom_range(0, 127));
            run_txn(ra, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                    1, ($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
